uart_top: RTL and testbench
===========================

UART_TOP -- requirements
Module: uart_top

Interface
REQ-001 Parameters SHALL be as follows:
- system_clk, default 50000000: clock frequency in Hz.
- band_rate, default 115200: baud rate.
- data_bits, default 8: payload bits per frame, range 5..8.
- check_mode, default 1: parity mode; 0 none, 1 odd, 2 even.
- stop_mode, default 0: 0 one stop bit, 1 two stop bits.
- tx_fifo_deepth, default 16: TX FIFO depth, power of 2.
- rx_fifo_deepth, default 16: RX FIFO depth, power of 2.

REQ-002 Ports SHALL be as follows. The design has one clock; reset is synchronous and active-high.
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- tx_en, in, 1: transmitter enable.
- s_axis_tdata, in, data_bits: TX payload.
- s_axis_tvalid, in, 1: TX payload valid.
- s_axis_tready, out, 1: TX FIFO can accept.
- tx, out, 1: serial output; idle level is high.
- rx_en, in, 1: receiver enable.
- rx, in, 1: serial input; asynchronous to clk.
- m_axis_tready, in, 1: sink ready.
- m_axis_tdata, out, data_bits: received payload.
- m_axis_tvalid, out, 1: received payload valid.
- check_flag, out, 1: one-cycle pulse on a bad received frame.

Function
REQ-003 Bit period DIV SHALL be system_clk/band_rate, truncated; the default is 434 cycles.
REQ-004 Frame format SHALL be: start bit 0, then data LSB first, then the parity bit if check_mode is nonzero, then 1 or 2 stop bits of 1.
REQ-005 The parity bit SHALL make the count of ones across data plus parity odd (check_mode 1) or even (check_mode 2).
REQ-006 TX FIFO:
- s_axis_tready SHALL equal !full.
- A word SHALL be pushed on any cycle where s_axis_tvalid and s_axis_tready are both high.
- Pushing while full SHALL be impossible, because tready is low when full.
REQ-007 TX FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
- It SHALL leave IDLE when tx_en=1 and the TX FIFO is non-empty, popping one word.
- tx SHALL drive the start bit no later than 2 cycles after the pop.
- Each bit SHALL last exactly DIV cycles.
- After the last stop bit the FSM SHALL return to IDLE; back-to-back frames are allowed with no extra idle time.
REQ-008 Deasserting tx_en mid-frame SHALL let the current frame complete; no new frame SHALL start until tx_en returns high.
REQ-009 RX FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
- In IDLE with rx_en=1, a falling edge on the sampled rx SHALL move the FSM to START.
- At DIV/2 the start bit SHALL be re-checked: if rx is still low the FSM proceeds; if high it is a false start and the FSM returns to IDLE.
- Every following bit SHALL be sampled at intervals of DIV from that mid-start point.
REQ-010 Frame acceptance:
- With a correct parity bit and a stop bit of 1, the payload SHALL be pushed into the RX FIFO one cycle after the stop sample.
- With a parity mismatch or a stop bit of 0, the frame SHALL be discarded and check_flag SHALL pulse high for exactly 1 cycle.
- For stop_mode 1, only the first stop bit SHALL be checked; the receiver SHALL return to IDLE after that sample.
REQ-011 The RX FIFO SHALL be first-word-fall-through.
- m_axis_tvalid SHALL equal !empty, with m_axis_tdata showing the head word.
- The head SHALL be popped when m_axis_tvalid and m_axis_tready are both high.
- A valid frame arriving while the RX FIFO is full SHALL be dropped silently.
REQ-012 rx_en=0 SHALL force the RX FSM to IDLE on the next cycle, aborting any frame in progress; RX FIFO contents SHALL be kept.
REQ-013 Both FIFOs SHALL accept a simultaneous push and pop in the same cycle; the count stays unchanged.

Reset
REQ-014 On rst high at a clk edge, the following SHALL hold from the next cycle:
- tx=1.
- Both FSMs in IDLE.
- Both FIFOs empty, so s_axis_tready=1 and m_axis_tvalid=0.
- m_axis_tdata=0.
- check_flag=0.
- All bit counters cleared.
REQ-015 Reset asserted mid-frame SHALL abort the frame with no partial output; tx returns high the next cycle.

Configuration
REQ-016 With UART_RX_SYNC_EN defined, rx SHALL pass through a 2-flop synchronizer before edge detection, adding 2 cycles of RX latency.
REQ-017 Without UART_RX_SYNC_EN, rx SHALL be registered once only.

Structure
REQ-018 Package uart_pkg SHALL hold:
- The TX and RX state encodings.
- The check_mode constants NONE=0, ODD=1, EVEN=2.
- The divisor calculation function.
REQ-019 Sub-module uart_fifo (synchronous, FWFT, depth and width parameterized) SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-020 Loopback (rx tied to tx, default parameters): push 0x55, 0xA3, 0x00, 0xFF -> m_axis delivers the same 4 bytes in order, and check_flag stays 0.
REQ-021 Frame timing, default parameters: one frame lasts 11 bits × 434 = 4774 cycles. For 0xA3, tx shows start 0, bits 1,1,0,0,0,1,0,1, parity 1, stop 1.
REQ-022 TX backpressure: with tx_en=0, push 17 words -> s_axis_tready goes low after the 16th word. Raising tx_en drains the FIFO, and tready returns high after the first pop.
REQ-023 Parity error: drive an external frame of 0x01 with parity bit 0 under odd parity -> a check_flag 1-cycle pulse and no push to the RX FIFO.
REQ-024 RX overflow: with m_axis_tready=0, loop back 17 bytes -> only the first 16 are stored. Raising m_axis_tready returns the first 16 bytes in order.
REQ-025 Reset mid-frame: assert rst during the DATA bits -> tx=1 the next cycle, m_axis_tvalid=0, and no frame is received.

Source files
------------

// File: rtl/uart_pkg.sv
// UART shared state encodings, parity-mode constants and divisor/parity helpers.
package uart_pkg;

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  localparam int unsigned CheckNone = 0;
  localparam int unsigned CheckOdd  = 1;
  localparam int unsigned CheckEven = 2;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Zero-padded upper bits do not disturb the reduction.
  function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
    return (mode == CheckOdd) ? ~(^data) : ((mode == CheckEven) ? ^data : 1'b0);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; Depth must be a power of 2.
module uart_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_wdata,
  output logic             o_full,
  input  logic             i_pop,
  output logic [Width-1:0] o_rdata,
  output logic             o_empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AddrW:0]   r_wptr;
  logic [AddrW:0]   r_rptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AddrW] != r_rptr[AddrW]) &&
                   (r_wptr[AddrW-1:0] == r_rptr[AddrW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AddrW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AddrW + 1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AddrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AddrW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_top.sv
// UART with AXI-Stream TX/RX FIFOs and configurable framing.
// Define UART_RX_SYNC_EN to add a 2-flop synchronizer ahead of the rx sampling flop.
module uart_top
  import uart_pkg::*;
#(
  parameter int unsigned system_clk     = 50000000,
  parameter int unsigned band_rate      = 115200,
  parameter int unsigned data_bits      = 8,
  parameter int unsigned check_mode     = 1,
  parameter int unsigned stop_mode      = 0,
  parameter int unsigned tx_fifo_deepth = 16,
  parameter int unsigned rx_fifo_deepth = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic [data_bits-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 tx,
  input  logic                 rx_en,
  input  logic                 rx,
  input  logic                 m_axis_tready,
  output logic [data_bits-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 check_flag
);

  localparam int unsigned    Div       = calc_div(system_clk, band_rate);
  localparam int unsigned    CntW      = $clog2(Div);
  localparam logic [CntW-1:0] CntLast  = CntW'(Div - 1);
  localparam logic [CntW-1:0] CntHalf  = CntW'(Div / 2 - 1);
  localparam logic [2:0]     BitLast   = 3'(data_bits - 1);
  localparam bit             HasParity = (check_mode != CheckNone);

  // ---------------- Transmit path ----------------
  logic                 w_tx_empty;
  logic                 w_tx_full;
  logic                 w_tx_pop;
  logic [data_bits-1:0] w_tx_head;
  logic                 w_tx_bit_end;
  logic                 w_tx_frame_end;
  tx_state_e            r_tx_state;
  logic [CntW-1:0]      r_tx_cnt;
  logic [2:0]           r_tx_bit;
  logic                 r_tx_stop;
  logic [data_bits-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_tx;

  uart_fifo #(
    .Depth (tx_fifo_deepth),
    .Width (data_bits)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (s_axis_tvalid),
    .i_wdata (s_axis_tdata),
    .o_full  (w_tx_full),
    .i_pop   (w_tx_pop),
    .o_rdata (w_tx_head),
    .o_empty (w_tx_empty)
  );

  assign s_axis_tready  = !w_tx_full;
  assign tx             = r_tx;
  assign w_tx_bit_end   = (r_tx_cnt == CntLast);
  assign w_tx_frame_end = (r_tx_state == TxStop) && w_tx_bit_end && (stop_mode == 0 || r_tx_stop);
  // Popping on the last stop cycle chains frames with no idle gap.
  assign w_tx_pop       = tx_en && !w_tx_empty && ((r_tx_state == TxIdle) || w_tx_frame_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TxIdle;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_stop  <= 1'b0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
    end else if (w_tx_pop) begin
      r_tx_state <= TxStart;
      r_tx_cnt   <= '0;
      r_tx_shift <= w_tx_head;
      r_tx_par   <= parity_bit(8'(w_tx_head), check_mode);
      r_tx       <= 1'b0;
    end else begin
      unique case (r_tx_state)
        TxIdle: r_tx <= 1'b1;
        TxStart: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= TxData;
            r_tx       <= r_tx_shift[0];
          end else begin
            r_tx_cnt <= r_tx_cnt + CntW'(1);
          end
        end
        TxData: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_shift <= r_tx_shift >> 1;
            if (r_tx_bit == BitLast) begin
              r_tx_stop  <= 1'b0;
              r_tx_state <= HasParity ? TxParity : TxStop;
              r_tx       <= HasParity ? r_tx_par : 1'b1;
            end else begin
              r_tx_bit <= r_tx_bit + 3'd1;
              r_tx     <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CntW'(1);
          end
        end
        TxParity: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_stop  <= 1'b0;
            r_tx_state <= TxStop;
            r_tx       <= 1'b1;
          end else begin
            r_tx_cnt <= r_tx_cnt + CntW'(1);
          end
        end
        TxStop: begin
          r_tx <= 1'b1;
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (stop_mode == 0 || r_tx_stop) r_tx_state <= TxIdle;
            else                             r_tx_stop  <= 1'b1;
          end else begin
            r_tx_cnt <= r_tx_cnt + CntW'(1);
          end
        end
        default: r_tx_state <= TxIdle;
      endcase
    end
  end

  // ---------------- Receive path ----------------
  logic w_rx_in;
  logic r_rx_s;
  logic r_rx_d;
  logic w_rx_fall;

`ifdef UART_RX_SYNC_EN
  logic r_rx_sync1;
  logic r_rx_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
    end else begin
      r_rx_sync1 <= rx;
      r_rx_sync2 <= r_rx_sync1;
    end
  end

  assign w_rx_in = r_rx_sync2;
`else
  assign w_rx_in = rx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s <= 1'b1;
      r_rx_d <= 1'b1;
    end else begin
      r_rx_s <= w_rx_in;
      r_rx_d <= r_rx_s;
    end
  end

  assign w_rx_fall = r_rx_d && !r_rx_s;

  rx_state_e            r_rx_state;
  logic [CntW-1:0]      r_rx_cnt;
  logic [2:0]           r_rx_bit;
  logic [data_bits-1:0] r_rx_shift;
  logic                 r_rx_par;
  logic                 r_rx_push;
  logic                 r_check_flag;
  logic                 w_rx_bit_end;
  logic                 w_rx_par_ok;
  logic                 w_rx_full;
  logic                 w_rx_empty;

  assign w_rx_bit_end = (r_rx_cnt == CntLast);
  assign w_rx_par_ok  = !HasParity || (parity_bit(8'(r_rx_shift), check_mode) == r_rx_par);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state   <= RxIdle;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_par     <= 1'b0;
      r_rx_push    <= 1'b0;
      r_check_flag <= 1'b0;
    end else begin
      r_rx_push    <= 1'b0;
      r_check_flag <= 1'b0;
      if (!rx_en) begin
        r_rx_state <= RxIdle;
        r_rx_cnt   <= '0;
        r_rx_bit   <= '0;
      end else begin
        unique case (r_rx_state)
          RxIdle: begin
            if (w_rx_fall) begin
              r_rx_state <= RxStart;
              r_rx_cnt   <= '0;
            end
          end
          RxStart: begin
            // Mid-start recheck; a high line here was a glitch.
            if (r_rx_cnt == CntHalf) begin
              r_rx_cnt   <= '0;
              r_rx_bit   <= '0;
              r_rx_state <= r_rx_s ? RxIdle : RxData;
            end else begin
              r_rx_cnt <= r_rx_cnt + CntW'(1);
            end
          end
          RxData: begin
            if (w_rx_bit_end) begin
              r_rx_cnt   <= '0;
              r_rx_shift <= {r_rx_s, r_rx_shift[data_bits-1:1]};
              if (r_rx_bit == BitLast) r_rx_state <= HasParity ? RxParity : RxStop;
              else                     r_rx_bit   <= r_rx_bit + 3'd1;
            end else begin
              r_rx_cnt <= r_rx_cnt + CntW'(1);
            end
          end
          RxParity: begin
            if (w_rx_bit_end) begin
              r_rx_cnt   <= '0;
              r_rx_par   <= r_rx_s;
              r_rx_state <= RxStop;
            end else begin
              r_rx_cnt <= r_rx_cnt + CntW'(1);
            end
          end
          RxStop: begin
            if (w_rx_bit_end) begin
              r_rx_cnt   <= '0;
              r_rx_state <= RxIdle;
              if (r_rx_s && w_rx_par_ok) r_rx_push    <= 1'b1;
              else                       r_check_flag <= 1'b1;
            end else begin
              r_rx_cnt <= r_rx_cnt + CntW'(1);
            end
          end
          default: r_rx_state <= RxIdle;
        endcase
      end
    end
  end

  uart_fifo #(
    .Depth (rx_fifo_deepth),
    .Width (data_bits)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_rx_push && !w_rx_full),
    .i_wdata (r_rx_shift),
    .o_full  (w_rx_full),
    .i_pop   (m_axis_tready),
    .o_rdata (m_axis_tdata),
    .o_empty (w_rx_empty)
  );

  assign m_axis_tvalid = !w_rx_empty;
  assign check_flag    = r_check_flag;

endmodule

// File: tb/tb_uart_top.sv
// Bench for uart_top: default-rate instance for frame timing/loopback, fast instance for the rest.
module tb_uart_top;

  localparam int unsigned DivA      = 434;  // 50 MHz / 115200, truncated
  localparam int unsigned DivB      = 10;   // 50 MHz / 5 MHz
  localparam int unsigned FrameBits = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: default parameters, rx looped back from tx.
  logic       a_rst = 1'b1;
  logic       a_s_tvalid = 1'b0;
  logic [7:0] a_s_tdata = '0;
  logic       a_s_tready, a_tx, a_m_tvalid, a_check_flag;
  logic [7:0] a_m_tdata;

  uart_top u_dut_a (
    .clk           (clk),
    .rst           (a_rst),
    .tx_en         (1'b1),
    .s_axis_tdata  (a_s_tdata),
    .s_axis_tvalid (a_s_tvalid),
    .s_axis_tready (a_s_tready),
    .tx            (a_tx),
    .rx_en         (1'b1),
    .rx            (a_tx),
    .m_axis_tready (1'b1),
    .m_axis_tdata  (a_m_tdata),
    .m_axis_tvalid (a_m_tvalid),
    .check_flag    (a_check_flag)
  );

  // Instance B: fast bit rate, rx selectable between loopback and an external driver.
  logic       b_rst = 1'b1;
  logic       b_tx_en = 1'b0, b_rx_en = 1'b1, b_loop = 1'b1, b_rx_ext = 1'b1;
  logic       b_s_tvalid = 1'b0, b_m_tready = 1'b1;
  logic [7:0] b_s_tdata = '0;
  logic       b_s_tready, b_tx, b_rx, b_m_tvalid, b_check_flag;
  logic [7:0] b_m_tdata;

  assign b_rx = b_loop ? b_tx : b_rx_ext;

  uart_top #(
    .band_rate (5000000)
  ) u_dut_b (
    .clk           (clk),
    .rst           (b_rst),
    .tx_en         (b_tx_en),
    .s_axis_tdata  (b_s_tdata),
    .s_axis_tvalid (b_s_tvalid),
    .s_axis_tready (b_s_tready),
    .tx            (b_tx),
    .rx_en         (b_rx_en),
    .rx            (b_rx),
    .m_axis_tready (b_m_tready),
    .m_axis_tdata  (b_m_tdata),
    .m_axis_tvalid (b_m_tvalid),
    .check_flag    (b_check_flag)
  );

  // Model: line image of an 8N-odd-1 frame, bit 0 first on the wire.
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    return {1'b1, ~(^d), d, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [7:0]  a_txq[$];
  logic [7:0]  a_rxq[$];
  logic [7:0]  b_rxq[$];
  int          a_pos = 0;
  logic [10:0] a_frame = '0;
  int          b_flags = 0;
  logic        b_flag_prev = 1'b0;

  // Compare process: tx waveform of A against the frame model, RX streams against queues.
  always @(negedge clk) begin
    if (!a_rst) begin
      if (a_pos == 0) begin
        if (a_tx == 1'b0) begin
          if (a_txq.size() == 0) begin
            check("a_tx_unexpected_start", a_tx, 1);
          end else begin
            a_frame = frame_bits(a_txq.pop_front());
            check("a_tx_start", a_tx, a_frame[0]);
            a_pos = 1;
          end
        end
      end else begin
        check("a_tx_bit", a_tx, a_frame[a_pos / DivA]);
        a_pos = (a_pos + 1 == FrameBits * DivA) ? 0 : a_pos + 1;
      end
      check("a_check_flag", a_check_flag, 0);
      if (a_m_tvalid) begin
        if (a_rxq.size() == 0) check("a_rx_unexpected", a_m_tvalid, 0);
        else                   check("a_rx_data", a_m_tdata, a_rxq.pop_front());
      end
    end
    if (!b_rst) begin
      if (b_m_tvalid && b_m_tready) begin
        if (b_rxq.size() == 0) check("b_rx_unexpected", b_m_tvalid, 0);
        else                   check("b_rx_data", b_m_tdata, b_rxq.pop_front());
      end
      if (b_check_flag) begin
        b_flags++;
        check("b_flag_one_cycle", b_flag_prev, 0);
      end
    end
    b_flag_prev = b_check_flag;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit to_b, input logic [7:0] d, input bit exp_rx);
    int n = 0;
    if (to_b) begin
      b_s_tdata  = d;
      b_s_tvalid = 1'b1;
      while (!b_s_tready && n < 4000) begin tick(); n++; end
      check("b_push_accepted", b_s_tready, 1);
      tick();
      b_s_tvalid = 1'b0;
      if (exp_rx) b_rxq.push_back(d);
    end else begin
      a_s_tdata  = d;
      a_s_tvalid = 1'b1;
      while (!a_s_tready && n < 4000) begin tick(); n++; end
      check("a_push_accepted", a_s_tready, 1);
      tick();
      a_s_tvalid = 1'b0;
      a_txq.push_back(d);
      a_rxq.push_back(d);
    end
  endtask

  // Drive an externally built frame into B; rx_en drops at bit abort_at (11 = never).
  task automatic send_ext(input logic [10:0] bits, input int abort_at);
    for (int k = 0; k < 11; k++) begin
      if (k == abort_at) b_rx_en = 1'b0;
      b_rx_ext = bits[k];
      repeat (DivB) tick();
    end
    b_rx_ext = 1'b1;
    repeat (3 * DivB) tick();
    b_rx_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0]  pin_d [4];
  logic [10:0] pin_f [4];
  logic [7:0]  stim  [4];
  int          n;
  int          exp_flags;

  initial begin
    pin_d = '{8'hA3, 8'h55, 8'h00, 8'hFF};
    pin_f = '{11'h746, 11'h6AA, 11'h600, 11'h7FE};
    stim  = '{8'h55, 8'hA3, 8'h00, 8'hFF};
    exp_flags = 0;

    for (int i = 0; i < 4; i++) check("model_frame_pin", frame_bits(pin_d[i]), pin_f[i]);

    repeat (3) tick();
    check("a_rst_tx", a_tx, 1);
    check("a_rst_tready", a_s_tready, 1);
    check("a_rst_tvalid", a_m_tvalid, 0);
    check("a_rst_tdata", a_m_tdata, 0);
    check("a_rst_flag", a_check_flag, 0);
    check("b_rst_tx", b_tx, 1);
    check("b_rst_tready", b_s_tready, 1);
    check("b_rst_tvalid", b_m_tvalid, 0);
    check("b_rst_tdata", b_m_tdata, 0);
    check("b_rst_flag", b_check_flag, 0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    tick();

    // A: single 0xA3 frame, start-bit latency, then a back-to-back loopback burst.
    push(1'b0, 8'hA3, 1'b1);
    n = 0;
    while (a_tx && n < 10) begin tick(); n++; end
    check("a_start_latency_le3", (n <= 3), 1);
    for (int i = 0; i < 4; i++) push(1'b0, stim[i], 1'b1);
    n = 0;
    while (a_rxq.size() != 0 && n < 6 * FrameBits * DivA) begin tick(); n++; end
    check("a_loopback_all_received", a_rxq.size(), 0);
    check("a_tx_all_sent", a_txq.size(), 0);

    // B: backpressure with the transmitter held off.
    for (int i = 0; i < 16; i++) begin
      check("b_tready_before_push", b_s_tready, 1);
      push(1'b1, 8'(i * 37 + 5), 1'b1);
    end
    check("b_tready_low_when_full", b_s_tready, 0);
    b_s_tdata  = 8'(16 * 37 + 5);
    b_s_tvalid = 1'b1;
    repeat (5) tick();
    check("b_tready_stays_low", b_s_tready, 0);
    b_tx_en = 1'b1;
    n = 0;
    while (!b_s_tready && n < 10) begin tick(); n++; end
    check("b_tready_after_first_pop", (n <= 3), 1);
    tick();
    b_s_tvalid = 1'b0;
    b_rxq.push_back(8'(16 * 37 + 5));
    n = 0;
    while (b_rxq.size() != 0 && n < 17 * FrameBits * DivB + 500) begin tick(); n++; end
    check("b_drain_all_received", b_rxq.size(), 0);

    // B: RX overflow; the 17th frame must vanish.
    b_m_tready = 1'b0;
    for (int i = 0; i < 17; i++) push(1'b1, 8'(i * 29 + 11), (i < 16));
    repeat (17 * FrameBits * DivB + 100) tick();
    check("b_overflow_tvalid", b_m_tvalid, 1);
    b_m_tready = 1'b1;
    n = 0;
    while (b_rxq.size() != 0 && n < 100) begin tick(); n++; end
    check("b_overflow_first16", b_rxq.size(), 0);
    repeat (3) tick();
    check("b_overflow_17th_dropped", b_m_tvalid, 0);

    // B: external frames. 0x01 has one set bit, so its odd-parity bit is 0.
    b_loop = 1'b0;
    repeat (2 * DivB) tick();
    check("model_frame_0x01", frame_bits(stim[2] | 8'h01), 11'h402);
    b_rxq.push_back(8'h01);
    send_ext(frame_bits(8'h01), 11);
    check("b_good_parity_received", b_rxq.size(), 0);
    check("b_good_parity_no_flag", b_flags, exp_flags);

    send_ext(frame_bits(8'h01) ^ 11'h200, 11);
    exp_flags++;
    check("b_bad_parity_flag", b_flags, exp_flags);
    check("b_bad_parity_no_push", b_m_tvalid, 0);

    send_ext(frame_bits(8'h5A) & 11'h3FF, 11);
    exp_flags++;
    check("b_bad_stop_flag", b_flags, exp_flags);
    check("b_bad_stop_no_push", b_m_tvalid, 0);

    b_rx_ext = 1'b0;
    repeat (3) tick();
    b_rx_ext = 1'b1;
    repeat (3 * FrameBits * DivB) tick();
    check("b_false_start_no_flag", b_flags, exp_flags);
    check("b_false_start_no_push", b_m_tvalid, 0);

    send_ext(frame_bits(8'h3C), 4);
    repeat (FrameBits * DivB) tick();
    check("b_rx_en_abort_no_flag", b_flags, exp_flags);
    check("b_rx_en_abort_no_push", b_m_tvalid, 0);

    // B: reset in the middle of the data bits.
    b_loop = 1'b1;
    push(1'b1, 8'hC6, 1'b0);
    n = 0;
    while (b_tx && n < 20) begin tick(); n++; end
    check("b_frame_started", b_tx, 0);
    repeat (3 * DivB) tick();
    b_rst = 1'b1;
    tick();
    check("b_tx_high_after_rst", b_tx, 1);
    check("b_tvalid_after_rst", b_m_tvalid, 0);
    b_rst = 1'b0;
    repeat (2 * FrameBits * DivB) tick();
    check("b_no_frame_after_rst", b_m_tvalid, 0);
    check("b_no_flag_after_rst", b_flags, exp_flags);
    check("b_tx_idle_after_rst", b_tx, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
